// File: rtl/unpacked_array_arbiter.sv
// Round-robin arbiter that gives M requesters one-access-per-cycle use of a shared
// single-port word array. After every reset an init sequencer zeroes the whole array.
module unpacked_array_arbiter #(
    parameter  int M     = 2,
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int IDW   = ($clog2(M) > 1) ? $clog2(M) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid [M],
    input  logic           req_we    [M],
    input  logic [AW-1:0]  req_addr  [M],
    input  logic [W-1:0]   req_wdata [M],
    output logic           req_ready [M],
    output logic [0:M-1]   grant_vec,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_rdata,
    output logic           busy
);

    typedef enum logic {INIT, SERVE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  init_ptr_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [W-1:0]   mem [DEPTH];

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [M-1:0]   gnt_oh;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [W-1:0]   sel_wdata;
    logic           in_range;
    logic [W-1:0]   rd_data;

    // Candidate index k places after the round-robin pointer, wrapped mod M.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s = int'(base) + k;
        return IDW'((s >= M) ? s - M : s);
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        if (state_q == INIT) begin
            if (init_ptr_q == AW'(DEPTH - 1))
                state_d = SERVE;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (!gnt_any && req_valid[rr_idx(rr_ptr_q, k)]) begin
                    gnt_any                     = 1'b1;
                    gnt_idx                     = rr_idx(rr_ptr_q, k);
                    gnt_oh[rr_idx(rr_ptr_q, k)] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        assign req_ready[i] = gnt_oh[i];
        assign grant_vec[i] = gnt_oh[i];
    end

    assign busy      = (state_q == INIT);
    assign sel_we    = req_we[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx];
    assign sel_wdata = req_wdata[gnt_idx];
    // Addresses past the last entry are accepted but touch nothing and read as zero.
    assign in_range  = int'(sel_addr) < DEPTH;
    assign rd_data   = in_range ? mem[sel_addr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            rr_ptr_q   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= gnt_any;
            if (state_q == INIT)
                init_ptr_q <= init_ptr_q + 1'b1;
            if (gnt_any) begin
                rsp_id    <= gnt_idx;
                rsp_rdata <= sel_we ? sel_wdata : rd_data;
                rr_ptr_q  <= (gnt_idx == IDW'(M - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the init sequencer clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == INIT)
                mem[init_ptr_q] <= '0;
            else if (gnt_any && sel_we && in_range)
                mem[sel_addr] <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_unpacked_array_arbiter.sv
// Bench for unpacked_array_arbiter: directed phases plus random traffic, all checked
// against a behavioural model of the array, the rotation order and the response.
module tb_unpacked_array_arbiter;
    localparam int M = 3, W = 8, DEPTH = 3, AW = 2, IDW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           req_valid [M];
    logic           req_we    [M];
    logic [AW-1:0]  req_addr  [M];
    logic [W-1:0]   req_wdata [M];
    logic           req_ready [M];
    logic [0:M-1]   grant_vec;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_rdata;
    logic           busy;

    always #5 clock = ~clock;

    unpacked_array_arbiter #(.M(M), .W(W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .grant_vec(grant_vec),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    int         total = 0, passed = 0;
    int         init_left, rr, e_id, since2;
    logic [W-1:0] mm [DEPTH];
    logic       e_v;
    logic [W-1:0] e_d;
    bit         fair_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic idle_all();
        for (int i = 0; i < M; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
        req_valid[i] = v; req_we[i] = we; req_addr[i] = AW'(a); req_wdata[i] = W'(d);
    endtask

    task automatic model_reset();
        init_left = DEPTH; rr = 0; e_v = 1'b0; e_id = 0; e_d = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    endtask

    // One clock: check the grant before the edge, then the response after it.
    task automatic cycle();
        int g, a;
        logic [M-1:0] exp_vec, act_rdy, act_gv;
        #1;
        g = -1;
        if (init_left == 0)
            for (int k = 0; k < M; k++)
                if (g < 0 && req_valid[(rr + k) % M]) g = (rr + k) % M;
        exp_vec = '0;
        if (g >= 0) exp_vec[g] = 1'b1;
        for (int i = 0; i < M; i++) begin
            act_rdy[i] = req_ready[i];
            act_gv[i]  = grant_vec[i];
        end
        chk("ready", 32'(act_rdy), 32'(exp_vec));
        chk("grant_vec", 32'(act_gv), 32'(exp_vec));
        @(posedge clock);
        #1;
        if (reset) begin
            model_reset();
        end else if (init_left > 0) begin
            init_left--;
            e_v = 1'b0;
        end else begin
            e_v = (g >= 0);
            if (g >= 0) begin
                a = int'(req_addr[g]);
                if (req_we[g]) begin
                    e_d = req_wdata[g];
                    if (a < DEPTH) mm[a] = req_wdata[g];
                end else begin
                    e_d = (a < DEPTH) ? mm[a] : '0;
                end
                e_id = g;
                rr   = (g + 1) % M;
                if (fair_mode) begin
                    since2 = (g == 2) ? 0 : since2 + 1;
                    chk("fair", 32'(since2 <= 2), 32'd1);
                end
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(e_v));
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_d));
        chk("busy", 32'(busy), 32'(init_left > 0));
    endtask

    initial begin
        idle_all();
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;

        // Requests during init are ignored.
        for (int i = 0; i < M; i++) set_req(i, 1, 1, i, 8'h77);
        for (int c = 0; c < DEPTH; c++) cycle();
        chk("init_done", 32'(busy), 32'd0);

        // Every entry reads back zero.
        for (int a = 0; a < DEPTH; a++) begin
            idle_all(); set_req(0, 1, 0, a, 0); cycle();
            chk("init_zero", 32'(rsp_rdata), 32'd0);
        end

        // Two requesters holding reads alternate.
        idle_all(); set_req(0, 1, 0, 1, 0); set_req(1, 1, 0, 1, 0);
        for (int c = 0; c < 6; c++) cycle();

        // Write then read-back from another requester.
        idle_all(); set_req(0, 1, 1, 2, 8'hA5); cycle();
        chk("wr_echo", 32'(rsp_rdata), 32'hA5);
        idle_all(); set_req(1, 1, 0, 2, 0); cycle();
        chk("rd_back", 32'(rsp_rdata), 32'hA5);

        // Out-of-range address: write dropped, read zero, others untouched.
        idle_all(); set_req(0, 1, 1, 3, 8'hFF); cycle();
        idle_all(); set_req(1, 1, 0, 3, 0); cycle();
        chk("oor_valid", 32'(rsp_valid), 32'd1);
        chk("oor_rd", 32'(rsp_rdata), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            idle_all(); set_req(2, 1, 0, a, 0); cycle();
        end

        // Fairness: requester 2 always valid, the others random.
        fair_mode = 1'b1; since2 = 0;
        for (int c = 0; c < 30; c++) begin
            set_req(0, $urandom % 2, 0, $urandom % 4, 0);
            set_req(1, $urandom % 2, 0, $urandom % 4, 0);
            set_req(2, 1, 0, $urandom % 4, 0);
            cycle();
        end
        fair_mode = 1'b0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < M; i++)
                set_req(i, $urandom % 2, $urandom % 2, $urandom % 4, $urandom % 256);
            reset = ($urandom % 40 == 0);
            cycle();
        end
        reset = 1'b0;
        idle_all();
        for (int c = 0; c <= DEPTH; c++) cycle();

        // Reset in the cycle a read is granted.
        set_req(0, 1, 1, 2, 8'hA5); cycle();
        idle_all(); set_req(0, 1, 0, 2, 0);
        reset = 1'b1; cycle();
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < DEPTH; c++) cycle();
        cycle();
        chk("midrst_rezero", 32'(rsp_rdata), 32'd0);
        idle_all(); cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/unpacked_array_arbiter.md
Name: unpacked_array_arbiter

Overview:
- Shares one single-port storage array `mem [DEPTH]` of W-bit words between M requesters.
- Requester signals are unpacked arrays declared by size.
- Arbitration is round-robin. At most one access per cycle. Every accepted access returns a one-cycle response.
- After reset, an init sequencer zeroes the whole array before any requester is served.

Parameters:
- M, 2: number of requesters (≥ 2).
- W, 8: data word width.
- DEPTH, 4: number of array entries (≥ 2; need not be a power of two).
- AW (derived localparam): max(1, $clog2(DEPTH)), address width.
- IDW (derived localparam): max(1, $clog2(M)), requester-ID width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1 x [M] unpacked  requester i has an access pending.
- req_we  input  1 x [M] unpacked  1 = write, 0 = read.
- req_addr  input  AW x [M] unpacked  target entry.
- req_wdata  input  W x [M] unpacked  write data.
- req_ready  output  1 x [M] unpacked  grant; a transfer occurs when req_valid[i] && req_ready[i].
- grant_vec  output  [0:M-1] packed  packed view of req_ready; grant_vec[i] == req_ready[i].
- rsp_valid  output  1  response pulse.
- rsp_id  output  IDW  index of the requester being answered.
- rsp_rdata  output  W  read data, or echo of the written data.
- busy  output  1  init sequence in progress.

Behaviour:
- Reset (sampled at clock edge while reset=1):
  - state←INIT, init_ptr←0, rr_ptr←0.
  - rsp_valid←0, rsp_id←0, rsp_rdata←0, busy←1.
  - req_ready and grant_vec are all 0 while in INIT.
- States: INIT, SERVE.
- INIT:
  - Each cycle: mem[init_ptr]←0, init_ptr←init_ptr+1.
  - The cycle that writes entry DEPTH-1 moves state to SERVE.
  - busy falls exactly DEPTH cycles after the first edge with reset=0.
  - All req_ready are 0; requests are ignored, not queued.
- SERVE, grant (combinational from req_valid and rr_ptr):
  - Search indices rr_ptr, rr_ptr+1, …, wrapping mod M. The first index with req_valid=1 gets req_ready=1.
  - At most one req_ready is high. With no valid request, all are 0.
- SERVE, on a transfer by requester g:
  - Write: mem[addr]←wdata.
  - Read: samples mem[addr] as it was before that edge.
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_rdata = read value or written value (write echo).
  - rr_ptr←(g+1) mod M. Without a transfer, rr_ptr holds.
- Response timing:
  - Latency is exactly 1 cycle; there is no backpressure.
  - Back-to-back transfers give rsp_valid high on consecutive cycles.
  - rsp_id and rsp_rdata hold their last value when rsp_valid=0.
- Address ≥ DEPTH: write dropped, read returns 0. The response is still issued and rr_ptr still advances.
- Read-after-write: a read in the cycle after a write to the same address returns the new data.
- Reset mid-operation: any in-flight response is suppressed (rsp_valid=0 the cycle after a reset edge), and the array is fully re-zeroed.
- A requester that deasserts req_valid while ungranted loses nothing. The pointer is unaffected.
- Storage must be declared as an unpacked array by size. Per-requester ports use size-declared unpacked arrays.

Test Plan:
- Init: reset 1 cycle, M=2, DEPTH=4 → busy=1 for 4 cycles, all req_ready=0; then read all 4 addresses → rdata=0 each, rsp_id correct.
- Round-robin: both requesters hold reads for 6 cycles → grants alternate 0,1,0,1,0,1; rsp_id alternates one cycle later; grant_vec matches req_ready.
- Write/read-back: req0 writes 0xA5 to addr 2, next cycle req1 reads addr 2 → req0 response echoes 0xA5; req1 rdata=0xA5 one cycle after its grant.
- Out of range (DEPTH=3): write 0xFF to addr 3, then read addr 3 → rsp_valid pulses for both, read rdata=0; addr 0..2 are unchanged.
- Mid-operation reset: assert reset in the cycle a read is granted → no rsp_valid follows; busy=1 for DEPTH cycles; previously written 0xA5 reads back 0.
- Fairness with M=3: req2 valid continuously, req0 and req1 toggling → req2 is granted at least once in every 3 transfers; no grant is given without valid.
